vga_timing_monitor: RTL and testbench
=====================================

VGA_TIMING_MONITOR -- requirements
Module: vga_timing_monitor

Interface
REQ-001 SHALL have parameter H_TOTAL, default 800: pixels per line.
REQ-002 SHALL have parameter H_ACTIVE, default 640: visible pixels per line.
REQ-003 SHALL have parameter H_SYNC_START, default 656: pixel index of the hs falling edge.
REQ-004 SHALL have parameter H_SYNC_LEN, default 96: hs low width, in pixels.
REQ-005 SHALL have parameter V_TOTAL, default 525; V_ACTIVE, default 480; V_SYNC_START, default 490; V_SYNC_LEN, default 2: the same quantities in lines.
REQ-006 SHALL have parameter LOCK_FRAMES, default 2: consecutive clean frames required to lock.
REQ-007 SHALL have port Clk, input, 1: single clock, 50 MHz.
REQ-008 SHALL have port Reset, input, 1: asynchronous, active-high reset.
REQ-009 SHALL have port PixelEn, input, 1: one-Clk strobe per pixel (25 MHz).
REQ-010 SHALL have port hs, input, 1: horizontal sync, active low.
REQ-011 SHALL have port vs, input, 1: vertical sync, active low.
REQ-012 SHALL have port blank, input, 1: active low; low means the pixel is visible.
REQ-013 SHALL have port RecX, output, 10: recovered horizontal coordinate.
REQ-014 SHALL have port RecY, output, 10: recovered vertical coordinate.
REQ-015 SHALL have port Locked, output, 1: high while the timing is verified.
REQ-016 SHALL have ports HErr, VErr and BlankErr, output, 1 each: one-Clk error pulses.
REQ-017 SHALL have port FrameStart, output, 1: one-Clk pulse at each vs falling edge.
REQ-018 SHALL have port FrameCount, output, 8: count of vs falling edges, wrapping at 255 to 0.

Function
REQ-019 SHALL sample hs, vs and blank only in Clk cycles where PixelEn=1; no register changes when PixelEn=0.
REQ-020 SHALL detect edges as the difference between the current and the previous PixelEn sample.
REQ-021 SHALL increment RecX on each PixelEn; at H_TOTAL-1 it SHALL wrap to 0 and increment RecY.
REQ-022 SHALL wrap RecY from V_TOTAL-1 to 0.
REQ-023 On an hs falling edge, SHALL compare the predicted RecX with H_SYNC_START; on mismatch, SHALL pulse HErr and force RecX=H_SYNC_START.
REQ-024 On an hs rising edge, SHALL pulse HErr if the measured low width is not equal to H_SYNC_LEN.
REQ-025 On a vs falling edge, SHALL compare the predicted RecY with V_SYNC_START; on mismatch, SHALL pulse VErr and force RecY=V_SYNC_START.
REQ-026 On a vs rising edge, SHALL pulse VErr if the vs low width, counted in lines, is not equal to V_SYNC_LEN.
REQ-027 SHALL saturate the pulse-width counters at 1023.
REQ-028 SHALL use a state machine with states UNLOCKED, ACQUIRE and LOCKED.
REQ-029 UNLOCKED SHALL go to ACQUIRE on the first vs falling edge, with RecY resynced per REQ-025 and the clean count cleared.
REQ-030 In ACQUIRE, each vs falling edge with no error since the previous one SHALL increment the clean count; reaching LOCK_FRAMES SHALL go to LOCKED.
REQ-031 Any HErr or VErr in ACQUIRE or LOCKED SHALL go to UNLOCKED on the next Clk.
REQ-032 Locked SHALL be 1 only in the LOCKED state.
REQ-033 HErr and VErr SHALL be suppressed in UNLOCKED; counter resync still applies.
REQ-034 If hs and vs edges occur in the same sample, SHALL resync horizontal first, then vertical, in the same cycle.
REQ-035 All outputs SHALL be registered, with 1 Clk latency after the qualifying PixelEn cycle.

Reset
REQ-036 On Reset assertion, SHALL immediately set RecX=0, RecY=0, FrameCount=0, Locked=0 and all pulses to 0, with the state machine in UNLOCKED.
REQ-037 SHALL set the previous-sample registers to 1 (syncs inactive) on reset.
REQ-038 Reset mid-frame SHALL discard lock; reacquisition SHALL need the full REQ-029/030 sequence.

Configuration
REQ-039 With VGA_MON_BLANK_CHECK_EN defined, in LOCKED, SHALL pulse BlankErr when blank does not equal NOT(RecX<H_ACTIVE AND RecY<V_ACTIVE).
REQ-040 A BlankErr SHALL NOT affect lock.
REQ-041 Without VGA_MON_BLANK_CHECK_EN, SHALL tie BlankErr to 0 and SHALL ignore the blank input.

Structure
REQ-042 SHALL place the default timing constants and the state enum type (UNLOCKED/ACQUIRE/LOCKED) in shared package vga_timing_pkg.
REQ-043 SHALL use one sub-module, sync_edge_meter, instanced twice (hs, vs): edge detection plus saturating low-width counter.

Verification
REQ-044 Nominal 640x480 source from reset, 3 frames -> Locked=1 after the 2nd clean vs fall after acquire; HErr=VErr=0; FrameCount=3.
REQ-045 While locked, shift one hs fall to RecX=650 -> HErr pulse; Locked=0 next Clk; RecX=656; relock after 2 clean frames.
REQ-046 hs low width 95 pixels -> HErr at the rising edge; UNLOCKED.
REQ-047 vs low for 3 lines -> VErr; Locked=0.
REQ-048 With the macro, force blank=1 at RecX=10, RecY=10 while locked -> single BlankErr pulse; Locked stays 1. Without the macro -> BlankErr=0.
REQ-049 Assert Reset mid-line while locked -> all outputs 0 within the same cycle; 256 frames after release -> FrameCount wraps to 0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared constants and types for the VGA timing monitor.
// Holds the default 640x480@60 timing constants, the pulse-width counter
// width and saturation limit, the monitor state type and a saturating
// increment helper used by the edge meters.
package vga_timing_pkg;

    localparam int unsigned DEF_H_TOTAL      = 32'd800;
    localparam int unsigned DEF_H_ACTIVE     = 32'd640;
    localparam int unsigned DEF_H_SYNC_START = 32'd656;
    localparam int unsigned DEF_H_SYNC_LEN   = 32'd96;
    localparam int unsigned DEF_V_TOTAL      = 32'd525;
    localparam int unsigned DEF_V_ACTIVE     = 32'd480;
    localparam int unsigned DEF_V_SYNC_START = 32'd490;
    localparam int unsigned DEF_V_SYNC_LEN   = 32'd2;
    localparam int unsigned DEF_LOCK_FRAMES  = 32'd2;

    localparam logic [9:0] CNT_MAX = 10'd1023;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } mon_state_e;

    // Increment that sticks at CNT_MAX instead of wrapping.
    function automatic logic [9:0] sat_inc(input logic [9:0] value_s);
        if (value_s == CNT_MAX) begin
            return value_s;
        end else begin
            return value_s + 10'd1;
        end
    endfunction

endpackage

// File: rtl/vga_timing_monitor_sync_edge_meter.sv
// sync_edge_meter: edge detector and low-width meter for one active-low sync.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   pix_en       - sample qualifier; nothing changes when low
//   sync_in      - sync level (active low)
//   unit_tick    - this sample starts a new width unit (every pixel for hs,
//                  first pixel of a line for vs)
//   fall_s       - this qualified sample is a falling edge
//   rise_s       - this qualified sample is a rising edge
//   low_width_r  - units the sync has been low so far, saturating at 1023
module sync_edge_meter
    import vga_timing_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_en,
    input  logic       sync_in,
    input  logic       unit_tick,
    output logic       fall_s,
    output logic       rise_s,
    output logic [9:0] low_width_r
);

    logic prev_r;

    assign fall_s = pix_en & prev_r & ~sync_in;
    assign rise_s = pix_en & ~prev_r & sync_in;

    // Previous qualified sample; syncs read as inactive (high) out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_r <= 1'b1;
        end else if (pix_en) begin
            prev_r <= sync_in;
        end
    end

    // Width counter: the falling sample is the first low unit, and each later
    // low sample that opens a new unit adds one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            low_width_r <= 10'd0;
        end else if (fall_s) begin
            low_width_r <= 10'd1;
        end else if (pix_en && !sync_in && unit_tick) begin
            low_width_r <= sat_inc(low_width_r);
        end
    end

endmodule

// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor: recovers pixel coordinates from a VGA sync stream and
// verifies its timing, locking after LOCK_FRAMES clean frames.
// Optional feature macro: VGA_MON_BLANK_CHECK_EN enables the blank-window
// check (BlankErr); without it BlankErr is 0 and blank is ignored.
// Ports:
//   Clk, Reset     - clock, asynchronous active-high reset
//   PixelEn        - one-Clk strobe per pixel; all sampling is qualified by it
//   hs, vs, blank  - active-low syncs and blank (blank low = visible pixel)
//   RecX, RecY     - recovered coordinate of the last sampled pixel
//   Locked         - timing verified
//   HErr, VErr     - one-Clk horizontal / vertical timing error pulses
//   BlankErr       - one-Clk blank mismatch pulse (only while locked)
//   FrameStart     - one-Clk pulse per vs falling edge
//   FrameCount     - vs falling edges seen, modulo 256
// All outputs are registered and follow the qualifying PixelEn cycle by 1 Clk.
module vga_timing_monitor
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_TOTAL      = DEF_H_TOTAL,
    parameter int unsigned H_ACTIVE     = DEF_H_ACTIVE,
    parameter int unsigned H_SYNC_START = DEF_H_SYNC_START,
    parameter int unsigned H_SYNC_LEN   = DEF_H_SYNC_LEN,
    parameter int unsigned V_TOTAL      = DEF_V_TOTAL,
    parameter int unsigned V_ACTIVE     = DEF_V_ACTIVE,
    parameter int unsigned V_SYNC_START = DEF_V_SYNC_START,
    parameter int unsigned V_SYNC_LEN   = DEF_V_SYNC_LEN,
    parameter int unsigned LOCK_FRAMES  = DEF_LOCK_FRAMES
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       PixelEn,
    input  logic       hs,
    input  logic       vs,
    input  logic       blank,
    output logic [9:0] RecX,
    output logic [9:0] RecY,
    output logic       Locked,
    output logic       HErr,
    output logic       VErr,
    output logic       BlankErr,
    output logic       FrameStart,
    output logic [7:0] FrameCount
);

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 32'd1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 32'd1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] H_SS   = 10'(H_SYNC_START);
    localparam logic [9:0] H_SL   = 10'(H_SYNC_LEN);
    localparam logic [9:0] V_SS   = 10'(V_SYNC_START);
    localparam logic [9:0] V_SL   = 10'(V_SYNC_LEN);
    localparam logic [7:0] LOCK_LAST = 8'(LOCK_FRAMES - 32'd1);

    mon_state_e state_r;
    logic [9:0] rec_x_r, rec_y_r;
    logic [7:0] clean_cnt_r, frame_cnt_r;
    logic       locked_r, herr_r, verr_r, berr_r, fstart_r;

    logic       line_end_s;
    logic [9:0] x_inc_s, y_inc_s, x_next_s, y_next_s;
    logic       hs_fall_s, hs_rise_s, vs_fall_s, vs_rise_s;
    logic [9:0] hs_width_s, vs_width_s;
    logic       h_bad_s, v_bad_s, herr_s, verr_s, lose_s;
    logic       visible_s, berr_s;

    // Free-running prediction of the coordinate of the current sample.
    assign line_end_s = (rec_x_r == H_LAST);
    assign x_inc_s    = line_end_s ? 10'd0 : rec_x_r + 10'd1;
    assign y_inc_s    = !line_end_s ? rec_y_r :
                        ((rec_y_r == V_LAST) ? 10'd0 : rec_y_r + 10'd1);

    sync_edge_meter u_hs_meter (
        .clk         (Clk),
        .rst         (Reset),
        .pix_en      (PixelEn),
        .sync_in     (hs),
        .unit_tick   (1'b1),
        .fall_s      (hs_fall_s),
        .rise_s      (hs_rise_s),
        .low_width_r (hs_width_s)
    );

    // vs width is measured in lines: a unit starts at each predicted line start.
    sync_edge_meter u_vs_meter (
        .clk         (Clk),
        .rst         (Reset),
        .pix_en      (PixelEn),
        .sync_in     (vs),
        .unit_tick   (line_end_s),
        .fall_s      (vs_fall_s),
        .rise_s      (vs_rise_s),
        .low_width_r (vs_width_s)
    );

    // Resync and error detection: horizontal first, then vertical on the
    // prediction that already includes any line wrap of this sample.
    always_comb begin
        x_next_s = x_inc_s;
        y_next_s = y_inc_s;
        h_bad_s  = 1'b0;
        v_bad_s  = 1'b0;
        if (hs_fall_s) begin
            h_bad_s  = (x_inc_s != H_SS);
            x_next_s = H_SS;
        end else if (hs_rise_s) begin
            h_bad_s = (hs_width_s != H_SL);
        end else begin
            h_bad_s = 1'b0;
        end
        if (vs_fall_s) begin
            v_bad_s  = (y_inc_s != V_SS);
            y_next_s = V_SS;
        end else if (vs_rise_s) begin
            v_bad_s = (vs_width_s != V_SL);
        end else begin
            v_bad_s = 1'b0;
        end
    end

    // Errors are only reported once the monitor has started tracking a frame.
    assign herr_s    = h_bad_s && (state_r != UNLOCKED);
    assign verr_s    = v_bad_s && (state_r != UNLOCKED);
    assign lose_s    = herr_s || verr_s;
    assign visible_s = (x_next_s < H_ACT) && (y_next_s < V_ACT);

`ifdef VGA_MON_BLANK_CHECK_EN
    // A sample that is already losing lock has untrustworthy coordinates.
    assign berr_s = PixelEn && (state_r == LOCKED) && !lose_s && (blank != !visible_s);
`else
    logic unused_blank_s;
    assign unused_blank_s = blank ^ visible_s;
    assign berr_s = 1'b0;
`endif

    // Lock state machine, coordinate registers and all registered outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r     <= UNLOCKED;
            rec_x_r     <= 10'd0;
            rec_y_r     <= 10'd0;
            clean_cnt_r <= 8'd0;
            frame_cnt_r <= 8'd0;
            locked_r    <= 1'b0;
            herr_r      <= 1'b0;
            verr_r      <= 1'b0;
            berr_r      <= 1'b0;
            fstart_r    <= 1'b0;
        end else if (PixelEn) begin
            rec_x_r  <= x_next_s;
            rec_y_r  <= y_next_s;
            herr_r   <= herr_s;
            verr_r   <= verr_s;
            berr_r   <= berr_s;
            fstart_r <= vs_fall_s;
            if (vs_fall_s) begin
                frame_cnt_r <= frame_cnt_r + 8'd1;
            end
            case (state_r)
                UNLOCKED: begin
                    if (vs_fall_s) begin
                        state_r     <= ACQUIRE;
                        clean_cnt_r <= 8'd0;
                    end
                end
                ACQUIRE: begin
                    if (lose_s) begin
                        state_r <= UNLOCKED;
                    end else if (vs_fall_s) begin
                        clean_cnt_r <= clean_cnt_r + 8'd1;
                        if (clean_cnt_r >= LOCK_LAST) begin
                            state_r  <= LOCKED;
                            locked_r <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (lose_s) begin
                        state_r  <= UNLOCKED;
                        locked_r <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= UNLOCKED;
                    locked_r <= 1'b0;
                end
            endcase
        end else begin
            // Pulses last exactly one Clk; state holds between pixels.
            herr_r   <= 1'b0;
            verr_r   <= 1'b0;
            berr_r   <= 1'b0;
            fstart_r <= 1'b0;
        end
    end

    assign RecX       = rec_x_r;
    assign RecY       = rec_y_r;
    assign Locked     = locked_r;
    assign HErr       = herr_r;
    assign VErr       = verr_r;
    assign BlankErr   = berr_r;
    assign FrameStart = fstart_r;
    assign FrameCount = frame_cnt_r;

endmodule

// File: tb/tb_vga_timing_monitor.sv
// tb_vga_timing_monitor: directed bench for vga_timing_monitor using a
// scaled-down raster (24x16 pixels) so whole frames are short.
// Expected BlankErr behaviour follows VGA_MON_BLANK_CHECK_EN.
module tb_vga_timing_monitor;

    localparam int HT = 24, HA = 16, HSS = 18, HSL = 3;
    localparam int VT = 16, VA = 12, VSS = 13, VSL = 2;
`ifdef VGA_MON_BLANK_CHECK_EN
    localparam int BERR_EXP = 1;
`else
    localparam int BERR_EXP = 0;
`endif

    logic       clk_s = 1'b0;
    logic       reset_s, pix_en_s, hs_s, vs_s, blank_s;
    logic [9:0] rec_x_s, rec_y_s;
    logic       locked_s, herr_s, verr_s, berr_s, fstart_s;
    logic [7:0] fcount_s;

    int tests_run = 0, tests_failed = 0;
    int tx = 0, ty = 0;
    int herr_cnt = 0, verr_cnt = 0, berr_cnt = 0, fs_cnt = 0;

    vga_timing_monitor #(
        .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_LEN(HSL),
        .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_LEN(VSL),
        .LOCK_FRAMES(2)
    ) dut (
        .Clk(clk_s), .Reset(reset_s), .PixelEn(pix_en_s),
        .hs(hs_s), .vs(vs_s), .blank(blank_s),
        .RecX(rec_x_s), .RecY(rec_y_s), .Locked(locked_s),
        .HErr(herr_s), .VErr(verr_s), .BlankErr(berr_s),
        .FrameStart(fstart_s), .FrameCount(fcount_s)
    );

    always #5 clk_s = ~clk_s;

    function automatic logic nom_hs(input int x);
        return !(x >= HSS && x < HSS + HSL);
    endfunction
    function automatic logic nom_vs(input int y);
        return !(y >= VSS && y < VSS + VSL);
    endfunction
    function automatic logic nom_bl(input int x, input int y);
        return !(x < HA && y < VA);
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One pixel: strobe for one Clk, sample outputs on the following negedge.
    task automatic px(input logic h, input logic v, input logic b);
        @(negedge clk_s);
        hs_s = h; vs_s = v; blank_s = b; pix_en_s = 1'b1;
        @(negedge clk_s);
        pix_en_s = 1'b0;
        herr_cnt += int'(herr_s);
        verr_cnt += int'(verr_s);
        berr_cnt += int'(berr_s);
        fs_cnt   += int'(fstart_s);
        tx++;
        if (tx == HT) begin
            tx = 0;
            ty = (ty == VT - 1) ? 0 : ty + 1;
        end
    endtask

    task automatic nom(input int n);
        for (int i = 0; i < n; i++) px(nom_hs(tx), nom_vs(ty), nom_bl(tx, ty));
    endtask

    initial begin
        reset_s = 1'b1; pix_en_s = 1'b0; hs_s = 1'b1; vs_s = 1'b1; blank_s = 1'b1;
        repeat (3) @(negedge clk_s);
        check("rst_recx", int'(rec_x_s), 0);
        check("rst_recy", int'(rec_y_s), 0);
        check("rst_fcount", int'(fcount_s), 0);
        check("rst_locked", int'(locked_s), 0);
        check("rst_pulses", int'({herr_s, verr_s, berr_s, fstart_s}), 0);
        @(negedge clk_s);
        reset_s = 1'b0;

        // Nominal source: acquire at frame 1 vs fall, lock at frame 3 vs fall.
        nom(2 * 384 + 13 * 24);
        check("prelock_locked", int'(locked_s), 0);
        check("prelock_fcount", int'(fcount_s), 2);
        nom(1);
        check("lock_locked", int'(locked_s), 1);
        check("lock_fstart", int'(fstart_s), 1);
        check("lock_recx", int'(rec_x_s), 0);
        check("lock_recy", int'(rec_y_s), VSS);
        check("lock_fcount", int'(fcount_s), 3);
        nom(71);
        check("eof3_recx", int'(rec_x_s), HT - 1);
        check("eof3_recy", int'(rec_y_s), VT - 1);
        check("nominal_herr", herr_cnt, 0);
        check("nominal_verr", verr_cnt, 0);
        check("nominal_fstarts", fs_cnt, 3);

        // hs fall moved 6 pixels early on line 2 of frame 4.
        herr_cnt = 0; verr_cnt = 0;
        nom(2 * 24 + 12);
        px(1'b0, 1'b1, nom_bl(tx, ty));
        check("hshift_herr", int'(herr_s), 1);
        check("hshift_locked", int'(locked_s), 0);
        check("hshift_recx", int'(rec_x_s), HSS);
        repeat (11) px(!(tx < 15), 1'b1, nom_bl(tx, ty));
        nom(312 + 384 + 312);
        check("relock_pending", int'(locked_s), 0);
        nom(1);
        check("relock_locked", int'(locked_s), 1);
        nom(71);
        check("hshift_herr_total", herr_cnt, 1);
        check("hshift_verr_total", verr_cnt, 0);

        // hs low one pixel short on line 1 of frame 7.
        nom(24 + 18);
        px(1'b0, 1'b1, nom_bl(tx, ty));
        px(1'b0, 1'b1, nom_bl(tx, ty));
        check("short_hs_pre_herr", int'(herr_s), 0);
        check("short_hs_pre_locked", int'(locked_s), 1);
        px(1'b1, 1'b1, nom_bl(tx, ty));
        check("short_hs_herr", int'(herr_s), 1);
        check("short_hs_locked", int'(locked_s), 0);
        nom(339 + 384 + 384);
        check("relock2_locked", int'(locked_s), 1);

        // vs low for three lines in frame 10.
        verr_cnt = 0;
        nom(13 * 24);
        repeat (72) px(nom_hs(tx), 1'b0, nom_bl(tx, ty));
        check("long_vs_pre_locked", int'(locked_s), 1);
        check("long_vs_pre_verr", verr_cnt, 0);
        nom(1);
        check("long_vs_verr", int'(verr_s), 1);
        check("long_vs_locked", int'(locked_s), 0);
        nom(383 + 384 + 384);
        check("relock3_locked", int'(locked_s), 1);
        check("frame14_fcount", int'(fcount_s), 13);

        // blank forced high at (10,10) of frame 14.
        nom(10 * 24 + 10);
        px(1'b1, 1'b1, 1'b1);
        check("blank_berr", int'(berr_s), BERR_EXP);
        check("blank_locked", int'(locked_s), 1);
        nom(1);
        check("blank_after_berr", int'(berr_s), 0);
        check("blank_total", berr_cnt, BERR_EXP);

        // Reset mid-line while locked: outputs clear without a clock edge.
        nom(5);
        @(negedge clk_s);
        #2 reset_s = 1'b1;
        #1;
        check("midrst_recx", int'(rec_x_s), 0);
        check("midrst_recy", int'(rec_y_s), 0);
        check("midrst_fcount", int'(fcount_s), 0);
        check("midrst_locked", int'(locked_s), 0);
        check("midrst_pulses", int'({herr_s, verr_s, berr_s, fstart_s}), 0);
        @(negedge clk_s);
        reset_s = 1'b0;

        // Sync activity without PixelEn must not move anything.
        repeat (4) begin
            @(negedge clk_s);
            vs_s = ~vs_s; hs_s = ~hs_s;
        end
        @(negedge clk_s);
        check("noen_recx", int'(rec_x_s), 0);
        check("noen_fcount", int'(fcount_s), 0);

        // 256 vs falls with a continuous strobe: FrameCount wraps to 0.
        for (int i = 0; i < 256; i++) begin
            @(negedge clk_s);
            vs_s = 1'b0; pix_en_s = 1'b1;
            @(negedge clk_s);
            vs_s = 1'b1;
            if (i == 254) check("wrap_fcount_255", int'(fcount_s), 255);
        end
        @(negedge clk_s);
        pix_en_s = 1'b0;
        check("wrap_fcount_0", int'(fcount_s), 0);
        check("wrap_locked", int'(locked_s), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
